prbs7_ber_checker: RTL
======================

// Module: prbs7_ber_checker
// PURPOSE
//  Receive-end counterpart of the 16QAM modulator's PRBS serial source.
//  Sits after demod_16QAM, runs on signal_clk, and self-synchronises a local PRBS7 (x^7+x^6+1) to the demodulated bit stream.
//  Once locked, it counts received bits and bit errors for loopback BER measurement, and detects loss of lock.
// PARAMETERS
//  LOCK_CNT    16  consecutive correct predictions needed in CHECK to declare lock
//  WIN_LEN     64  length, in valid bits, of the loss-of-lock error window in LOCKED
//  LOSS_THRESH 8   errors within one window that force loss of lock (1 <= LOSS_THRESH <= WIN_LEN)
//  CNT_W       32  width of bit_cnt and err_cnt
// PORTS
//  signal_clk  in   1      bit-rate clock; all logic is on its rising edge
//  reset       in   1      asynchronous, active-high reset
//  data_in     in   1      demodulated serial bit
//  data_valid  in   1      data_in is sampled only when this is 1; when 0 nothing advances
//  clear       in   1      synchronous clear of bit_cnt/err_cnt; lock state is unaffected
//  locked      out  1      1 while FSM is in LOCKED
//  bit_cnt     out  CNT_W  valid bits checked while LOCKED (saturating)
//  err_cnt     out  CNT_W  mismatched bits while LOCKED (saturating)
//  err_pulse   out  1      1-cycle pulse: the bit sampled on the previous edge mismatched (LOCKED only)
//  lock_lost   out  1      1-cycle pulse on the LOCKED->SEED transition
// BEHAVIOUR
//  Reset: FSM=SEED, lfsr=0, seed/match/window counters=0; all outputs 0. All outputs are registered.
//  lfsr[6:0]: prediction pred = lfsr[6]^lfsr[5]. Every step below occurs only on a data_valid=1 edge.
//  SEED: lfsr <= {lfsr[5:0],data_in}; seed_cnt++. After the 7th bit, go to CHECK (match_cnt=0).
//  CHECK:
//   - entry with lfsr==7'h00 is illegal (PRBS7 has no 7-zero run): go back to SEED, seed_cnt=0.
//   - data_in==pred: lfsr <= {lfsr[5:0],pred}; match_cnt++. On the LOCK_CNT-th match, go to LOCKED.
//   - data_in!=pred: go to SEED, seed_cnt=0.
//   - bits in SEED/CHECK are never counted.
//  LOCKED: lfsr free-runs, lfsr <= {lfsr[5:0],pred}; received bits are never loaded.
//   - each valid bit: bit_cnt++; on mismatch also err_cnt++, err_pulse=1, win_errs++.
//   - win_bits counts 0..WIN_LEN-1. After the bit taken at WIN_LEN-1: win_bits=0, win_errs=0.
//   - if win_errs including the current bit reaches LOSS_THRESH: go to SEED, seed_cnt=0; lock_lost=1 for 1 cycle.
//     That bit is still counted in bit_cnt/err_cnt.
//  Latency: locked rises on the edge that samples the LOCK_CNT-th match.
//   Clean stream from reset: locked=1 after exactly 7+LOCK_CNT valid bits.
//  Counters saturate at all-ones. Once bit_cnt saturates, both counters freeze.
//  clear=1: both counters go to 0 on that edge; clear wins over an increment on the same edge (that bit is not counted).
//   err_pulse still fires for that bit.
//  data_valid=0: FSM, lfsr, counters and windows hold; err_pulse/lock_lost are 0.
//  Async reset mid-operation: immediate return to reset state; a clean stream then relocks in 7+LOCK_CNT valid bits.
// TESTING
//  1 Clean PRBS7 stream (seed 7'h7F), data_valid=1 -> locked=1 after 23 bits.
//    bit_cnt=100 after 100 further bits; err_cnt=0.
//  2 Locked, flip 1 bit -> err_pulse for exactly 1 cycle; err_cnt=1; locked stays 1.
//  3 Locked, flip 8 bits within one 64-bit window -> lock_lost pulse; locked=0.
//    Clean stream resumes -> relock after 23 bits; err_cnt=8 retained.
//  4 Locked, data_valid toggled 1/0 every cycle for 40 cycles -> bit_cnt +20; all state held on invalid cycles.
//  5 Locked, clear=1 on a mismatching bit -> bit_cnt=0, err_cnt=0, err_pulse=1, locked=1.
//  6 Constant-zero input -> locked never asserts; counters stay 0.
//    reset pulsed mid-CHECK -> all outputs 0 immediately.

Source files
------------

// File: rtl/prbs7_ber_checker_if.sv
// Bit-stream input and BER/lock status outputs of the PRBS7 checker.
interface prbs7_ber_checker_if #(
  parameter int unsigned CNT_W = 32
);
  logic             data_in;
  logic             data_valid;
  logic             clear;
  logic             locked;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             err_pulse;
  logic             lock_lost;

  modport master (
    output data_in, data_valid, clear,
    input  locked, bit_cnt, err_cnt, err_pulse, lock_lost
  );

  modport slave (
    input  data_in, data_valid, clear,
    output locked, bit_cnt, err_cnt, err_pulse, lock_lost
  );
endinterface

// File: rtl/prbs7_ber_checker.sv
// Self-synchronising PRBS7 (x^7+x^6+1) checker: seeds from the stream, verifies,
// then free-runs while counting bits/errors and watching for loss of lock.
module prbs7_ber_checker #(
  parameter int unsigned LOCK_CNT    = 16,
  parameter int unsigned WIN_LEN     = 64,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned CNT_W       = 32
) (
  input logic                signal_clk,
  input logic                reset,
  prbs7_ber_checker_if.slave bus
);

  typedef enum logic [1:0] {SEED, CHECK, LOCKED} state_t;

  localparam int unsigned MC_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int unsigned WB_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int unsigned WE_W = $clog2(LOSS_THRESH + 1);

  localparam logic [MC_W-1:0] MATCH_LAST = MC_W'(LOCK_CNT - 1);
  localparam logic [WB_W-1:0] WIN_LAST   = WB_W'(WIN_LEN - 1);
  localparam logic [WE_W-1:0] THRESH     = WE_W'(LOSS_THRESH);

  state_t           state_q, state_d;
  logic [6:0]       lfsr_q, lfsr_d;
  logic [2:0]       seed_cnt_q, seed_cnt_d;
  logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
  logic [WB_W-1:0]  win_bits_q, win_bits_d;
  logic [WE_W-1:0]  win_errs_q, win_errs_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             lock_lost_q, lock_lost_d;

  logic             pred;
  logic             mism;
  logic [WE_W-1:0]  win_errs_inc;

  assign pred         = lfsr_q[6] ^ lfsr_q[5];
  assign mism         = bus.data_in ^ pred;
  assign win_errs_inc = win_errs_q + WE_W'(mism);

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    win_bits_d  = win_bits_q;
    win_errs_d  = win_errs_q;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
    lock_lost_d = 1'b0;

    if (bus.data_valid) begin
      case (state_q)
        SEED: begin
          lfsr_d = {lfsr_q[5:0], bus.data_in};
          if (seed_cnt_q == 3'd6) begin
            state_d     = CHECK;
            seed_cnt_d  = '0;
            match_cnt_d = '0;
          end else begin
            seed_cnt_d = seed_cnt_q + 3'd1;
          end
        end
        CHECK: begin
          // An all-zero register would predict zeros forever, so it is treated as a failed seed.
          if (lfsr_q == '0 || mism) begin
            state_d    = SEED;
            seed_cnt_d = '0;
          end else begin
            lfsr_d = {lfsr_q[5:0], pred};
            if (match_cnt_q == MATCH_LAST) begin
              state_d    = LOCKED;
              win_bits_d = '0;
              win_errs_d = '0;
            end else begin
              match_cnt_d = match_cnt_q + MC_W'(1);
            end
          end
        end
        LOCKED: begin
          lfsr_d      = {lfsr_q[5:0], pred};
          err_pulse_d = mism;
          // Counters freeze together once bit_cnt saturates.
          if (bit_cnt_q != '1) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (mism && err_cnt_q != '1)
              err_cnt_d = err_cnt_q + CNT_W'(1);
          end
          if (win_errs_inc >= THRESH) begin
            state_d     = SEED;
            seed_cnt_d  = '0;
            lock_lost_d = 1'b1;
            win_bits_d  = '0;
            win_errs_d  = '0;
          end else if (win_bits_q == WIN_LAST) begin
            win_bits_d = '0;
            win_errs_d = '0;
          end else begin
            win_bits_d = win_bits_q + WB_W'(1);
            win_errs_d = win_errs_inc;
          end
        end
        default: state_d = SEED;
      endcase
    end

    if (bus.clear) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge signal_clk or posedge reset) begin
    if (reset) begin
      state_q     <= SEED;
      lfsr_q      <= '0;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_bits_q  <= '0;
      win_errs_q  <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_bits_q  <= win_bits_d;
      win_errs_q  <= win_errs_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.bit_cnt   = bit_cnt_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.lock_lost = lock_lost_q;

endmodule
